frame_response_arbiter: RTL
===========================

Name: frame_response_arbiter

Overview:
- Sequences the response frame builder and shares it between two response sources: the main bridge path (M), which carries full read/write responses, and the error reporter (E), which sends header-only error frames.
- Arbitrates round-robin, latches the winner's fields, and issues a single-cycle build pulse.
- Tracks the builder through busy and complete, with timeouts, then acknowledges the requester.
- Sits between the bridge/parser-error logic and the frame builder feeding UART TX.

Parameters:
- BUSY_TIMEOUT, 8: max cycles from build pulse to fb_builder_busy high.
- DONE_TIMEOUT, 8192: max cycles in WAIT_DONE. Must cover 70 bytes under TX FIFO backpressure.
- ERR_STATUS_SUBST, 8'hFF: status substituted when E requests with status 0x00.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_req  in  1  main response request; level, held until m_ack
- m_status  in  8  main status code
- m_cmd  in  8  main command echo
- m_addr  in  32  main address echo
- m_is_read  in  1  main read-response flag
- m_data_count  in  6  main data byte count; data array is wired directly to the builder
- m_ack  out  1  one-cycle pulse: M frame finished or timed out
- e_req  in  1  error response request; level, held until e_ack
- e_status  in  8  error status code
- e_cmd  in  8  error command echo
- e_ack  out  1  one-cycle pulse: E frame finished or timed out
- resp_timeout  out  1  qualifies m_ack/e_ack in the same cycle: frame aborted by timeout
- fb_status_code  out  8  to builder
- fb_cmd_echo  out  8  to builder
- fb_addr_echo  out  32  to builder
- fb_data_count  out  6  to builder
- fb_is_read  out  1  to builder
- fb_build_response  out  1  to builder; one-cycle pulse
- fb_builder_busy  in  1  from builder
- fb_response_complete  in  1  from builder; one-cycle pulse
- arb_busy  out  1  state != IDLE
- grant_id  out  1  0=M, 1=E; valid while arb_busy
- timeout_err  out  1  sticky; set on any timeout
- timeout_clr  in  1  clears timeout_err; a same-cycle new timeout wins

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1 (so M wins the first contest).
- FSM transitions:
  - IDLE -> LATCH when (m_req|e_req) && !fb_builder_busy.
  - LATCH -> PULSE.
  - PULSE -> WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE on fb_builder_busy. A complete seen here also counts, and goes straight to ACK.
  - WAIT_DONE -> ACK on fb_response_complete.
  - ACK -> GAP.
  - GAP -> IDLE.
- Arbitration in IDLE:
  - Single requester wins.
  - Both requesting: grant the one not equal to last_grant; update last_grant at LATCH.
- LATCH captures the fields; fb_* outputs stay stable from PULSE through ACK.
  - M path: fields passed as given.
  - E path: fb_addr_echo=0, fb_data_count=0, fb_is_read=0. fb_status_code=e_status, or ERR_STATUS_SUBST if e_status==0x00, so the builder never emits address/data for an error frame.
- fb_build_response is high only in PULSE and is guaranteed low in the preceding cycle, so the builder's edge detector fires exactly once.
- Latency: request in IDLE at cycle N gives fb_build_response at N+2. The ack is one cycle after fb_response_complete.
- Timeout counter:
  - Reset on entry to WAIT_BUSY and WAIT_DONE; 16-bit, saturating.
  - Reaching BUSY_TIMEOUT or DONE_TIMEOUT goes to ACK with resp_timeout=1 and sets timeout_err.
- ACK pulses exactly one of m_ack/e_ack per grant_id. GAP gives the requester one cycle to drop req; req is not sampled in ACK or GAP.
- A request deasserted before its ack is a protocol violation. The arbiter ignores it and completes the frame.
- Reset mid-frame aborts immediately: no ack, fb_build_response low.

Optional Feature:
- FRAME_ARB_STATS_EN: adds outputs stat_m_frames[15:0], stat_e_frames[15:0] and stat_timeouts[15:0].
  - Counters increment at ACK by grant_id; timeouts count separately.
  - Counters saturate at 0xFFFF and clear on rst only.
- Without the macro: ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package frame_arb_pkg: FSM state enum (IDLE, LATCH, PULSE, WAIT_BUSY, WAIT_DONE, ACK, GAP), GRANT_M/GRANT_E constants, and STATUS_OK=8'h00.
- One natural sub-module: frame_arb_rr2, a 2-way round-robin picker (req[1:0], last_grant in; grant_id, grant_valid out).

Test Plan:
- m_req with cmd=0x21, status=0x00, count=4; builder model asserts busy 1 cycle after the pulse and complete 10 cycles later -> pulse at N+2, fields stable, m_ack one cycle after complete, resp_timeout=0.
- m_req and e_req together from reset -> M granted first, then E; E frame shows fb_addr_echo=0, fb_data_count=0, fb_is_read=0.
- e_req with e_cmd=0xA0, e_status=0x00 -> fb_status_code=0xFF, fb_is_read=0.
- Builder model never raises busy -> after 8 cycles, ack with resp_timeout=1 and timeout_err=1; timeout_clr then clears it.
- fb_builder_busy already high while m_req arrives -> no pulse until busy drops; rst asserted in WAIT_DONE -> all outputs 0, no ack.

Source files
------------

// File: rtl/frame_arb_pkg.sv
// Shared types and constants for the frame response arbiter: FSM state
// encoding, grant identifiers, latched frame fields and a saturating counter helper.
package frame_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE,
    WAIT_BUSY,
    WAIT_DONE,
    ACK,
    GAP
  } arb_state_t;

  localparam logic GRANT_M = 1'b0;
  localparam logic GRANT_E = 1'b1;

  localparam logic [7:0] STATUS_OK = 8'h00;

  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [5:0]  count;
    logic        is_read;
  } frame_fields_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/frame_response_arbiter_if.sv
// Bus between the frame response arbiter (master) and the frame builder (slave).
interface frame_response_arbiter_if;

  logic [7:0]  fb_status_code;
  logic [7:0]  fb_cmd_echo;
  logic [31:0] fb_addr_echo;
  logic [5:0]  fb_data_count;
  logic        fb_is_read;
  logic        fb_build_response;
  logic        fb_builder_busy;
  logic        fb_response_complete;

  modport master (
    output fb_status_code,
    output fb_cmd_echo,
    output fb_addr_echo,
    output fb_data_count,
    output fb_is_read,
    output fb_build_response,
    input  fb_builder_busy,
    input  fb_response_complete
  );

  modport slave (
    input  fb_status_code,
    input  fb_cmd_echo,
    input  fb_addr_echo,
    input  fb_data_count,
    input  fb_is_read,
    input  fb_build_response,
    output fb_builder_busy,
    output fb_response_complete
  );

endinterface

// File: rtl/frame_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins; on contention the
// requester that did not win last time is granted.
module frame_arb_rr2
  import frame_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    if (&req) grant_id = ~last_grant;
    else      grant_id = req[GRANT_E] ? GRANT_E : GRANT_M;
  end

endmodule

// File: rtl/frame_response_arbiter.sv
// Shares the response frame builder between the main bridge path (M) and the
// error reporter (E). Optional statistics counters are enabled by FRAME_ARB_STATS_EN.
module frame_response_arbiter
  import frame_arb_pkg::*;
#(
  parameter int         BUSY_TIMEOUT     = 8,
  parameter int         DONE_TIMEOUT     = 8192,
  parameter logic [7:0] ERR_STATUS_SUBST = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m_req,
  input  logic [7:0]  m_status,
  input  logic [7:0]  m_cmd,
  input  logic [31:0] m_addr,
  input  logic        m_is_read,
  input  logic [5:0]  m_data_count,
  output logic        m_ack,

  input  logic        e_req,
  input  logic [7:0]  e_status,
  input  logic [7:0]  e_cmd,
  output logic        e_ack,

  output logic        resp_timeout,

  frame_response_arbiter_if.master fb,

  output logic        arb_busy,
  output logic        grant_id,
  output logic        timeout_err,
  input  logic        timeout_clr
`ifdef FRAME_ARB_STATS_EN
  ,
  output logic [15:0] stat_m_frames,
  output logic [15:0] stat_e_frames,
  output logic [15:0] stat_timeouts
`endif
);

  localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] DONE_LIMIT = 16'(DONE_TIMEOUT - 1);

  arb_state_t    state, state_next;
  logic          grant_q, last_grant;
  logic          rr_grant_id, rr_grant_valid;
  frame_fields_t fields_q, fields_in;
  logic [15:0]   tmo_cnt;
  logic          tmo_hit, tmo_flag;
  logic          timeout_err_q;
  logic          build_pulse;

  frame_arb_rr2 u_rr2 (
    .req         ({e_req, m_req}),
    .last_grant  (last_grant),
    .grant_id    (rr_grant_id),
    .grant_valid (rr_grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    tmo_hit    = 1'b0;
    case (state)
      IDLE:      if (rr_grant_valid && !fb.fb_builder_busy) state_next = LATCH;
      LATCH:     state_next = PULSE;
      PULSE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (fb.fb_response_complete)  state_next = ACK;
        else if (fb.fb_builder_busy)  state_next = WAIT_DONE;
        else if (tmo_cnt >= BUSY_LIMIT) begin
          state_next = ACK;
          tmo_hit    = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (fb.fb_response_complete) state_next = ACK;
        else if (tmo_cnt >= DONE_LIMIT) begin
          state_next = ACK;
          tmo_hit    = 1'b1;
        end
      end
      ACK:       state_next = GAP;
      GAP:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    build_pulse  = (state == PULSE);
    arb_busy     = (state != IDLE);
    m_ack        = (state == ACK) && (grant_q == GRANT_M);
    e_ack        = (state == ACK) && (grant_q == GRANT_E);
    resp_timeout = (state == ACK) && tmo_flag;
  end

  // Error frames never carry address or data, and a zero status is replaced
  // so the host cannot mistake an error frame for a success.
  always_comb begin
    fields_in = '0;
    if (grant_q == GRANT_M) begin
      fields_in.status  = m_status;
      fields_in.cmd     = m_cmd;
      fields_in.addr    = m_addr;
      fields_in.count   = m_data_count;
      fields_in.is_read = m_is_read;
    end else begin
      fields_in.status  = (e_status == STATUS_OK) ? ERR_STATUS_SUBST : e_status;
      fields_in.cmd     = e_cmd;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= GRANT_M;
      last_grant    <= GRANT_E;
      fields_q      <= '0;
      tmo_cnt       <= '0;
      tmo_flag      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_flag <= tmo_hit;
      tmo_cnt  <= (state_next != state) ? 16'd0 : sat_inc16(tmo_cnt);
      if (state == IDLE && state_next == LATCH) grant_q <= rr_grant_id;
      if (state == LATCH) begin
        last_grant <= grant_q;
        fields_q   <= fields_in;
      end
      if (tmo_hit)          timeout_err_q <= 1'b1;
      else if (timeout_clr) timeout_err_q <= 1'b0;
    end
  end

  assign fb.fb_status_code    = fields_q.status;
  assign fb.fb_cmd_echo       = fields_q.cmd;
  assign fb.fb_addr_echo      = fields_q.addr;
  assign fb.fb_data_count     = fields_q.count;
  assign fb.fb_is_read        = fields_q.is_read;
  assign fb.fb_build_response = build_pulse;
  assign grant_id             = grant_q;
  assign timeout_err          = timeout_err_q;

`ifdef FRAME_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_m_frames <= '0;
      stat_e_frames <= '0;
      stat_timeouts <= '0;
    end else if (state == ACK) begin
      if (grant_q == GRANT_M) stat_m_frames <= sat_inc16(stat_m_frames);
      else                    stat_e_frames <= sat_inc16(stat_e_frames);
      if (tmo_flag)           stat_timeouts <= sat_inc16(stat_timeouts);
    end
  end
`endif

endmodule
